// File: rtl/des_serial_paral.sv
// Serial-to-parallel deserializer: rebuilds N-bit words from an LSB-first bit
// stream and holds each one on Q under a V/R handshake, with sticky OV/FE flags.
module des_serial_paral #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          CK,
  input  logic          CL,
  input  logic          SE,
  input  logic          EN,
  input  logic          SY,
  input  logic          R,
  input  logic          CF,
  output logic [N-1:0]  Q,
  output logic          V,
  output logic          OV,
  output logic          FE,
  output logic [CW-1:0] BC
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] bc_q, bc_d;
  logic          v_q, v_d;
  logic          ov_q, ov_d;
  logic          fe_q, fe_d;
  logic [N-1:0]  shifted;
  logic          word_done;
  logic          ov_set;
  logic          fe_set;

  assign shifted = {SE, s_q[N-1:1]};

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bc_d      = bc_q;
    word_done = 1'b0;
    fe_set    = 1'b0;
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (SY) begin
            s_d     = shifted;
            bc_d    = CW'(1);
            state_d = RECV;
          end
        end
        default: begin
          if (SY) begin
            s_d    = shifted;
            bc_d   = CW'(1);
            fe_set = (bc_q != '0);
          end else if (bc_q == CW'(N - 1)) begin
            s_d       = shifted;
            bc_d      = '0;
            word_done = 1'b1;
          end else begin
            s_d  = shifted;
            bc_d = bc_q + CW'(1);
          end
        end
      endcase
    end
  end

  // A completing word is accepted when the holding register is empty or is
  // being drained on this same edge; otherwise it is dropped as an overrun.
  always_comb begin
    q_d    = q_q;
    v_d    = v_q;
    ov_set = 1'b0;
    if (word_done) begin
      if (!v_q || R) begin
        q_d = shifted;
        v_d = 1'b1;
      end else begin
        ov_set = 1'b1;
      end
    end else if (v_q && R) begin
      v_d = 1'b0;
    end
    ov_d = ov_set | (ov_q & ~CF);
    fe_d = fe_set | (fe_q & ~CF);
  end

  always_ff @(posedge CK or posedge CL) begin
    if (CL) begin
      state_q <= IDLE;
      s_q     <= '0;
      q_q     <= '0;
      bc_q    <= '0;
      v_q     <= 1'b0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      q_q     <= q_d;
      bc_q    <= bc_d;
      v_q     <= v_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
    end
  end

  assign Q  = q_q;
  assign V  = v_q;
  assign OV = ov_q;
  assign FE = fe_q;
  assign BC = bc_q;

endmodule
